// File: rtl/spi_master_word.sv
// Word-oriented SPI mode-0 master (MOSI/SCK, MSB first) feeding the LED matrix / MAX7219 path.
// Optional receive path on MISO is enabled by defining SPI_MASTER_RX_EN.
module spi_master_word #(
    parameter int   MAIN_CLK   = 50_000_000,
    parameter int   SERIAL_CLK = 1_000_000,
    parameter int   BITS       = 16,
    parameter logic SCK_IDLE   = 1'b0
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic [BITS-1:0] in_data,
    output logic            out_ready,
    output logic            out_next_word,
    output logic            out_clk,
    output logic            out_serial,
    input  logic            in_serial,
    output logic [BITS-1:0] out_data
);

    localparam int HALF = MAIN_CLK / SERIAL_CLK / 2;
    localparam int HW   = $clog2(HALF) + 1;
    localparam int BW   = $clog2(BITS) + 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] shreg, shreg_nxt;
    logic [BW-1:0]   bit_ctr, bit_nxt;
    logic [HW-1:0]   half_ctr, half_nxt;
    logic            next_word;
    logic            half_done;

    assign half_done = (half_ctr == HALF_LAST);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_ctr   <= '0;
            half_ctr  <= '0;
            next_word <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_ctr   <= bit_nxt;
            half_ctr  <= half_nxt;
            next_word <= (state_nxt != IDLE) && (bit_nxt == '0);
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_ctr;
        half_nxt  = half_ctr;
        case (state)
            IDLE: begin
                if (in_enable) begin
                    shreg_nxt = in_data;
                    bit_nxt   = BIT_LAST;
                    half_nxt  = '0;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (half_done) begin
                    half_nxt  = '0;
                    state_nxt = HIGH;
                end else begin
                    half_nxt = half_ctr + 1'b1;
                end
            end
            HIGH: begin
                if (half_done) begin
                    half_nxt = '0;
                    if (bit_ctr != '0) begin
                        shreg_nxt = {shreg[BITS-2:0], 1'b0};
                        bit_nxt   = bit_ctr - 1'b1;
                        state_nxt = LOW;
                    end else if (in_enable) begin
                        // back-to-back word: reload on the same edge, no idle gap
                        shreg_nxt = in_data;
                        bit_nxt   = BIT_LAST;
                        state_nxt = LOW;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    half_nxt = half_ctr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from reset flops so an async reset drops them immediately.
    assign out_ready     = (state == IDLE);
    assign out_next_word = next_word;
    assign out_clk       = (state == HIGH) ^ SCK_IDLE;
    assign out_serial    = (state != IDLE) & shreg[BITS-1];

`ifdef SPI_MASTER_RX_EN
    logic [BITS-1:0] rx_shreg;
    logic [BITS-1:0] rx_word;
    logic            rx_sample;
    logic            word_end;

    assign rx_sample = (state == LOW) && half_done;
    assign word_end  = (state == HIGH) && half_done && (bit_ctr == '0);

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rx_shreg <= '0;
            rx_word  <= '0;
        end else begin
            if (rx_sample)
                rx_shreg <= {rx_shreg[BITS-2:0], in_serial};
            if (word_end)
                rx_word <= rx_shreg;
        end
    end

    assign out_data = rx_word;
`else
    logic unused_serial;
    assign unused_serial = in_serial;
    assign out_data      = '0;
`endif

endmodule

// File: tb/tb_spi_master_word.sv
// Directed bench for spi_master_word (HALF=2): single word, back-to-back, enable drop,
// reset mid-word, inverted SCK idle and the MISO loopback receive path.
module tb_spi_master_word;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] din = '0;

    logic        rdy, nw, sck, mosi;
    logic [15:0] dout;
    logic        rdy_i, nw_i, sck_i, mosi_i;
    logic [15:0] dout_i;

    int total = 0;
    int bad   = 0;

    int          mon_cnt = 0;
    logic [63:0] mon_bits = '0;
    int          mon_cnt_i = 0;
    logic [63:0] mon_bits_i = '0;

    int low, nwc, nwf, ib, c0, ci0, seen;
    logic nw_prev;
    logic [15:0] rx_exp;

    always #5 clk = ~clk;

    spi_master_word #(.MAIN_CLK(4), .SERIAL_CLK(1), .BITS(16), .SCK_IDLE(1'b0)) dut (
        .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_data(din),
        .out_ready(rdy), .out_next_word(nw), .out_clk(sck), .out_serial(mosi),
        .in_serial(mosi), .out_data(dout)
    );

    spi_master_word #(.MAIN_CLK(4), .SERIAL_CLK(1), .BITS(16), .SCK_IDLE(1'b1)) dut_inv (
        .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_data(din),
        .out_ready(rdy_i), .out_next_word(nw_i), .out_clk(sck_i), .out_serial(mosi_i),
        .in_serial(mosi_i), .out_data(dout_i)
    );

    // slave-side capture: rising SCK for the normal part, falling out_clk for the inverted one
    always @(posedge sck) begin
        mon_bits <= {mon_bits[62:0], mosi};
        mon_cnt  <= mon_cnt + 1;
    end

    always @(negedge sck_i) begin
        mon_bits_i <= {mon_bits_i[62:0], mosi_i};
        mon_cnt_i  <= mon_cnt_i + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Pulse enable for one cycle, then watch the word until out_ready returns.
    task automatic run_word(input logic [15:0] d, output int lo, output int nc,
                            output int nf, output int ibad);
        din = d;
        en  = 1'b1;
        @(negedge clk);
        en   = 1'b0;
        lo   = 0;
        nc   = 0;
        nf   = 0;
        ibad = 0;
        for (int j = 1; j <= 200; j++) begin
            if (rdy) break;
            lo++;
            if (nw) begin
                nc++;
                if (nf == 0) nf = j;
            end
            if (sck_i !== ~sck || mosi_i !== mosi) ibad++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready",    32'(rdy),   32'd1);
        chk("rst_next",     32'(nw),    32'd0);
        chk("rst_sck",      32'(sck),   32'd0);
        chk("rst_mosi",     32'(mosi),  32'd0);
        chk("rst_data",     32'(dout),  32'd0);
        chk("rst_sck_inv",  32'(sck_i), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // single word
        c0  = mon_cnt;
        ci0 = mon_cnt_i;
        run_word(16'h0C01, low, nwc, nwf, ib);
        chk("single_ready_low",  32'(low), 32'd64);
        chk("single_nw_cycles",  32'(nwc), 32'd4);
        chk("single_nw_first",   32'(nwf), 32'd61);
        chk("single_bits",       32'(mon_bits[15:0]), 32'h0C01);
        chk("single_edges",      32'(mon_cnt - c0), 32'd16);
        chk("inv_track",         32'(ib), 32'd0);
        chk("inv_bits",          32'(mon_bits_i[15:0]), 32'h0C01);
        chk("inv_edges",         32'(mon_cnt_i - ci0), 32'd16);
        chk("single_ready_end",  32'(rdy), 32'd1);
        chk("single_sck_idle",   32'(sck), 32'd0);
        chk("single_mosi_idle",  32'(mosi), 32'd0);
        chk("inv_sck_idle",      32'(sck_i), 32'd1);

        // back-to-back: swap data on each next_word rise, drop enable during word two
        c0      = mon_cnt;
        din     = 16'h0A0F;
        en      = 1'b1;
        low     = 0;
        seen    = 0;
        nw_prev = 1'b0;
        @(negedge clk);
        for (int j = 1; j <= 400; j++) begin
            if (rdy) break;
            low++;
            if (nw && !nw_prev) begin
                seen++;
                if (seen == 1) din = 16'h0B07;
                else if (seen == 2) begin
                    en  = 1'b0;
                    din = 16'hFFFF;
                end
            end
            nw_prev = nw;
            @(negedge clk);
        end
        chk("b2b_ready_low", 32'(low), 32'd128);
        chk("b2b_nw_rises",  32'(seen), 32'd2);
        chk("b2b_edges",     32'(mon_cnt - c0), 32'd32);
        chk("b2b_bits",      mon_bits[31:0], 32'h0A0F_0B07);
        chk("b2b_ready_end", 32'(rdy), 32'd1);

        // enable dropped after three bits: word still completes
        c0  = mon_cnt;
        din = 16'h0F00;
        en  = 1'b1;
        @(negedge clk);
        chk("drop_ready_n1", 32'(rdy), 32'd0);
        repeat (12) @(negedge clk);
        en  = 1'b0;
        din = 16'hFFFF;
        low = 12;
        for (int j = 0; j <= 200; j++) begin
            if (rdy) break;
            low++;
            @(negedge clk);
        end
        chk("drop_ready_low", 32'(low), 32'd64);
        chk("drop_bits",      32'(mon_bits[15:0]), 32'h0F00);
        chk("drop_edges",     32'(mon_cnt - c0), 32'd16);

        // reset asserted in the high phase of bit 5
        c0  = mon_cnt;
        din = 16'h0C01;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (22) @(negedge clk);
        chk("mid_sck_pre",   32'(sck), 32'd1);
        chk("mid_mosi_pre",  32'(mosi), 32'd1);
        chk("mid_edges_pre", 32'(mon_cnt - c0), 32'd6);
        chk("mid_bits_pre",  32'(mon_bits[5:0]), 32'h03);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sck",     32'(sck), 32'd0);
        chk("mid_rst_mosi",    32'(mosi), 32'd0);
        chk("mid_rst_ready",   32'(rdy), 32'd1);
        chk("mid_rst_next",    32'(nw), 32'd0);
        chk("mid_rst_sck_inv", 32'(sck_i), 32'd1);
        repeat (2) @(negedge clk);
        chk("mid_rst_edges", 32'(mon_cnt - c0), 32'd6);
        rst_n = 1'b1;
        @(negedge clk);
        c0 = mon_cnt;
        run_word(16'h0C01, low, nwc, nwf, ib);
        chk("post_rst_ready_low", 32'(low), 32'd64);
        chk("post_rst_bits",      32'(mon_bits[15:0]), 32'h0C01);
        chk("post_rst_edges",     32'(mon_cnt - c0), 32'd16);

        // receive path with MISO looped back to MOSI
`ifdef SPI_MASTER_RX_EN
        rx_exp = 16'hA55A;
`else
        rx_exp = 16'h0000;
`endif
        run_word(16'hA55A, low, nwc, nwf, ib);
        chk("rx_tx_bits", 32'(mon_bits[15:0]), 32'hA55A);
        chk("rx_data",     32'(dout), 32'(rx_exp));
        chk("rx_data_inv", 32'(dout_i), 32'(rx_exp));
        repeat (3) @(negedge clk);
        chk("rx_data_hold", 32'(dout), 32'(rx_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
